// File: rtl/byte_serial_adder_ctrl.sv
// byte_serial_adder_ctrl
// Wide (8*NBYTES-bit) add/subtract performed one byte per clock through an
// 8-bit carry-in/carry-out slice, LSB byte first, chaining the carry.
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-high reset
//   start     request, sampled only while idle
//   sub       0 = a + b + cin, 1 = a - b (cin ignored); captured with start
//   cin       carry-in for add; captured with start
//   a, b      operands, captured with start
//   busy      high while byte slices are being processed
//   done      one-cycle pulse when the result is complete
//   sum       result register (updates byte by byte while busy)
//   cout      carry out of the MSB (for subtract: 1 = no borrow)
//   overflow  signed overflow of the full-width result
//   zero      full-width result is zero
module byte_serial_adder_ctrl #(
  parameter int unsigned NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  sub,
  input  logic                  cin,
  input  logic [8*NBYTES-1:0]   a,
  input  logic [8*NBYTES-1:0]   b,
  output logic                  busy,
  output logic                  done,
  output logic [8*NBYTES-1:0]   sum,
  output logic                  cout,
  output logic                  overflow,
  output logic                  zero
);

  localparam int unsigned W    = 8 * NBYTES;
  localparam int unsigned IDXW = $clog2(NBYTES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_nx;
  logic [IDXW-1:0]   idx_q, idx_nx;
  logic [W-1:0]      opa_q, opa_nx;
  logic [W-1:0]      opb_q, opb_nx;
  logic              carry_q, carry_nx;
  logic [W-1:0]      sum_nx;
  logic              cout_nx, ovf_nx, zero_nx;
  logic              busy_nx, done_nx;
  logic [7:0]        byte_a, byte_b;
  logic [8:0]        slice;

  // State, operand and result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      carry_q  <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_nx;
      idx_q    <= idx_nx;
      opa_q    <= opa_nx;
      opb_q    <= opb_nx;
      carry_q  <= carry_nx;
      sum      <= sum_nx;
      cout     <= cout_nx;
      overflow <= ovf_nx;
      zero     <= zero_nx;
      busy     <= busy_nx;
      done     <= done_nx;
    end
  end

  // Next-state, byte slice and result update
  always_comb begin
    state_nx = state_q;
    idx_nx   = idx_q;
    opa_nx   = opa_q;
    opb_nx   = opb_q;
    carry_nx = carry_q;
    sum_nx   = sum;
    cout_nx  = cout;
    ovf_nx   = overflow;
    zero_nx  = zero;

    byte_a = opa_q[8*idx_q +: 8];
    byte_b = opb_q[8*idx_q +: 8];
    slice  = 9'(byte_a) + 9'(byte_b) + 9'(carry_q);

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          // Subtract is a + ~b + 1: invert b now and seed the carry with 1
          opa_nx   = a;
          opb_nx   = sub ? ~b : b;
          carry_nx = sub ? 1'b1 : cin;
          idx_nx   = '0;
          state_nx = S_RUN;
        end
      end
      S_RUN: begin
        sum_nx[8*idx_q +: 8] = slice[7:0];
        carry_nx             = slice[8];
        idx_nx               = idx_q + IDXW'(1);
        if (idx_q == IDXW'(NBYTES - 1)) begin
          cout_nx  = slice[8];
          // Carry into bit 7 recovered as a7 ^ b7 ^ s7
          ovf_nx   = byte_a[7] ^ byte_b[7] ^ slice[7] ^ slice[8];
          // Top byte is still being written this edge, so use the fresh slice
          zero_nx  = ({slice[7:0], sum[W-9:0]} == '0);
          idx_nx   = '0;
          state_nx = S_DONE;
        end
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase

    busy_nx = (state_nx == S_RUN);
    done_nx = (state_nx == S_DONE);
  end

endmodule

// File: tb/tb_byte_serial_adder_ctrl.sv
// Self-checking bench for byte_serial_adder_ctrl: a word-level reference model
// checked against the DUT every cycle, plus literal per-operation results.
module tb_byte_serial_adder_ctrl;

  localparam int unsigned NBYTES = 4;
  localparam int unsigned W      = 8 * NBYTES;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic         cin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, cout, overflow, zero;
  logic [W-1:0] sum;

  int vectors = 0;
  int errors  = 0;

  byte_serial_adder_ctrl #(.NBYTES(NBYTES)) dut (
    .clk(clk), .reset(reset), .start(start), .sub(sub), .cin(cin),
    .a(a), .b(b), .busy(busy), .done(done), .sum(sum),
    .cout(cout), .overflow(overflow), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Word-level model: phase 0 idle, 1..NBYTES busy, NBYTES+1 done
  int           m_phase = 0;
  logic [W:0]   m_pend;
  logic         m_pend_ovf;
  logic [W-1:0] m_sum = '0;
  logic         m_cout = 1'b0, m_ovf = 1'b0, m_zero = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase = 0;
      m_sum   = '0;
      m_cout  = 1'b0;
      m_ovf   = 1'b0;
      m_zero  = 1'b0;
    end else if (m_phase == 0) begin
      if (start) begin
        logic [W-1:0] bb;
        bb         = sub ? ~b : b;
        m_pend     = {1'b0, a} + {1'b0, bb} + (W+1)'(sub ? 1'b1 : cin);
        m_pend_ovf = (a[W-1] == bb[W-1]) && (m_pend[W-1] != a[W-1]);
        m_phase    = 1;
      end
    end else if (m_phase == NBYTES + 1) begin
      m_phase = 0;
    end else begin
      m_phase = m_phase + 1;
      if (m_phase == NBYTES + 1) begin
        m_sum  = m_pend[W-1:0];
        m_cout = m_pend[W];
        m_ovf  = m_pend_ovf;
        m_zero = (m_pend[W-1:0] == '0);
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (!reset) begin
      logic m_busy;
      m_busy = (m_phase >= 1) && (m_phase <= NBYTES);
      check("busy", 64'(busy), 64'(m_busy));
      check("done", 64'(done), 64'(m_phase == NBYTES + 1));
      check("cout", 64'(cout), 64'(m_cout));
      check("overflow", 64'(overflow), 64'(m_ovf));
      check("zero", 64'(zero), 64'(m_zero));
      if (!m_busy) check("sum", 64'(sum), 64'(m_sum));
    end
  end

  // One operation from idle; scrambles inputs right after acceptance
  task automatic run_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tsub, input logic tcin, input logic [W-1:0] es,
                        input logic ec, input logic eo, input logic ez);
    int nbusy;
    bit got;
    @(negedge clk);
    a = ta; b = tb; sub = tsub; cin = tcin; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); sub = 1'($urandom); cin = 1'($urandom);
    nbusy = 0;
    got   = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (done) got = 1'b1;
      else begin
        if (busy) nbusy++;
        @(negedge clk);
      end
    end
    check({name, " done_seen"}, 64'(got), 64'(1));
    check({name, " busy_cycles"}, 64'(nbusy), 64'(NBYTES));
    check({name, " sum"}, 64'(sum), 64'(es));
    check({name, " cout"}, 64'(cout), 64'(ec));
    check({name, " overflow"}, 64'(overflow), 64'(eo));
    check({name, " zero"}, 64'(zero), 64'(ez));
    @(negedge clk);
    check({name, " done_width"}, 64'(done), 64'(0));
  endtask

  initial begin
    int d0, d1, cyc, ndone;
    bit got;

    #12;
    check("reset busy", 64'(busy), 64'(0));
    check("reset done", 64'(done), 64'(0));
    check("reset sum", 64'(sum), 64'(0));
    check("reset flags", 64'({cout, overflow, zero}), 64'(0));
    @(negedge clk);
    reset = 1'b0;

    run_op("add_basic", 32'h00000096, 32'h00000071, 1'b0, 1'b0, 32'h00000107, 1'b0, 1'b0, 1'b0);
    run_op("ripple",    32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1);
    run_op("sub_basic", 32'h00000054, 32'h00000035, 1'b1, 1'b1, 32'h0000001F, 1'b1, 1'b0, 1'b0);
    run_op("sub_borrow",32'h00000000, 32'h00000001, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
    run_op("ovf_add",   32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0);
    run_op("ovf_sub",   32'h80000000, 32'h00000001, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0);

    // Start pulsed during RUN with other operands must be ignored
    @(negedge clk);
    a = 32'h12345678; b = 32'h11111111; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 32'hDEADBEEF; b = 32'h01010101; sub = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (done) got = 1'b1;
      else @(negedge clk);
    end
    check("ignore_start done_seen", 64'(got), 64'(1));
    check("ignore_start sum", 64'(sum), 64'(32'h23456789));
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("ignore_start no_second_done", 64'(ndone), 64'(0));

    // Start held high: accepted every NBYTES+2 cycles
    @(negedge clk);
    a = 32'h00000010; b = 32'h00000020; sub = 1'b0; cin = 1'b0; start = 1'b1;
    d0 = -1; d1 = -1;
    for (cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (done) begin
        if (d0 < 0) d0 = cyc;
        else if (d1 < 0) d1 = cyc;
      end
    end
    start = 1'b0;
    check("b2b first_done", 64'(d0 >= 0), 64'(1));
    check("b2b spacing", 64'(d1 - d0), 64'(NBYTES + 2));
    check("b2b sum", 64'(sum), 64'(32'h00000030));
    for (int i = 0; i < 20 && (busy || done); i++) @(negedge clk);

    // Reset on the second RUN cycle aborts the operation
    @(negedge clk);
    a = 32'hCAFEF00D; b = 32'h00000001; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("rst_mid busy", 64'(busy), 64'(0));
    check("rst_mid done", 64'(done), 64'(0));
    check("rst_mid sum", 64'(sum), 64'(0));
    check("rst_mid flags", 64'({cout, overflow, zero}), 64'(0));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    check("rst_mid no_done", 64'(ndone), 64'(0));
    run_op("after_rst", 32'h0000FF00, 32'h00000100, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/byte_serial_adder_ctrl.md
# byte_serial_adder_ctrl

Multi-cycle sequencer that performs a wide (8·NBYTES-bit) add or subtract by stepping an 8-bit carry-in/carry-out add slice one byte per clock, LSB byte first, and chaining the carry between bytes. It sits beside the ALU's 8-bit carry-select adder and gives the datapath a wide add/sub path without widening that adder. Operands are captured on a start pulse. A one-cycle done pulse marks the result valid, together with carry-out, signed-overflow and zero flags.

## Interface
- NBYTES, 4, number of 8-bit slices per operation (≥2); operand width W = 8·NBYTES.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- sub  in  1  0 = add, 1 = subtract (a − b); captured with start.
- cin  in  1  carry-in for add; ignored when sub=1.
- a  in  W  operand A; captured with start.
- b  in  W  operand B; captured with start.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse, high in DONE.
- sum  out  W  result register.
- cout  out  1  carry out of MSB slice (for sub: 1 = no borrow).
- overflow  out  1  signed overflow = carry into MSB bit XOR carry out of MSB bit.
- zero  out  1  sum == 0.

## Operation
- State machine: IDLE, RUN, DONE.
- IDLE:
  - On start=1, latch a into opA.
  - Latch opB = sub ? ~b : b.
  - Set carry = sub ? 1 : cin, idx = 0, and go to RUN.
  - start=0 stays in IDLE.
- RUN, each edge:
  - {c8, s8} = opA[idx] + opB[idx] + carry, as a 9-bit result.
  - Write sum[8·idx+7 : 8·idx] = s8, then set carry = c8 and idx = idx+1.
  - On the edge processing idx = NBYTES−1:
    - Set cout = c8.
    - Set overflow = carry into bit 7 of that slice XOR c8.
    - Set zero from the completed W-bit result, including the byte written on this edge.
    - Go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE on the next edge.
- Operand capture:
  - Operands are registered at acceptance.
  - Changes on a/b/sub/cin after the accepting edge have no effect on the operation in flight.
- Start rules:
  - start is ignored in RUN and DONE. It is not queued.
  - start in the IDLE cycle right after DONE is accepted normally.
- Output validity:
  - sum updates byte by byte during RUN. Consumers use it only when done=1 or later in IDLE.
  - cout/overflow/zero change only on the last RUN edge.
  - sum/cout/overflow/zero hold until the last RUN edge of the next operation.
- Arithmetic is modulo 2^W with no saturation. Subtract is two's complement: a + ~b + 1.

## Timing
- Reset (asynchronous, immediate):
  - state = IDLE, idx = 0.
  - busy, done, sum, cout, overflow, zero all 0; internal operand and carry registers 0.
- Reset during RUN or DONE aborts the operation. No done pulse follows.
- Latency, with start accepted at edge E0:
  - busy is high from E0 to E_NBYTES.
  - done is high for the one cycle between E_NBYTES and E_NBYTES+1.
  - Result is valid from E_NBYTES.
- Throughput: one operation per NBYTES+2 cycles at best (accept, NBYTES slices, DONE).
- done and busy are never high together.

## Test plan
Default NBYTES=4 for all scenarios.
- Basic add with timing: a=0x00000096, b=0x00000071, sub=0, cin=0, start one cycle.
  - Requires sum=0x00000107, cout=0, overflow=0, zero=0.
  - busy high for exactly 4 cycles, then done high for exactly 1 cycle.
- Full carry ripple: a=0xFFFFFFFF, b=0x00000000, cin=1.
  - Requires sum=0x00000000, cout=1, zero=1, overflow=0.
- Subtract:
  - a=0x00000054, b=0x00000035, sub=1 (cin=1 applied) → sum=0x0000001F, cout=1, overflow=0; cin ignored.
  - a=0, b=1, sub=1 → sum=0xFFFFFFFF, cout=0.
- Signed overflow:
  - 0x7FFFFFFF + 0x00000001 → sum=0x80000000, overflow=1, cout=0.
  - 0x80000000 − 0x00000001 → sum=0x7FFFFFFF, overflow=1.
- Control corners:
  - Pulse start again during RUN with different operands → ignored; the first result completes unchanged and no second done appears.
  - Change a/b on the cycle after acceptance → result still uses the captured operands.
  - Back-to-back: start held high continuously → accepted every 6 cycles.
- Reset mid-operation: assert reset on the 2nd RUN cycle.
  - All outputs are 0 immediately and state is IDLE.
  - No done follows.
  - A fresh start after release completes correctly.
